// File: rtl/graph_mem_loader_if.sv
// rtl/graph_mem_loader_if.sv - memory read bus and record output stream of the graph loader
interface graph_mem_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_index;
  logic              out_is_edge;

  // Loader side: issues reads, consumes returns, produces the record stream.
  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_valid, mem_rd_data,
    output out_valid, out_data, out_index, out_is_edge,
    input  out_ready
  );

  // Environment side: graph memory plus the consuming vertex/edge buffers.
  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_valid, mem_rd_data,
    input  out_valid, out_data, out_index, out_is_edge,
    output out_ready
  );
endinterface

// File: rtl/graph_mem_loader.sv
// rtl/graph_mem_loader.sv - fetches vertex then edge table and streams tagged records through a skid FIFO
module graph_mem_loader #(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 9,
  parameter int                VERTEX_COUNT = 256,
  parameter int                EDGE_COUNT   = 256,
  parameter logic [ADDR_W-1:0] VERTEX_BASE  = 9'h000,
  parameter logic [ADDR_W-1:0] EDGE_BASE    = 9'h100,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic proto_err,
  graph_mem_loader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BW    = $clog2(VERTEX_COUNT + EDGE_COUNT);

  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0]   V_LAST  = BW'(VERTEX_COUNT - 1);
  localparam logic [BW-1:0]   E_LAST  = BW'(EDGE_COUNT - 1);
  localparam logic [BW-1:0]   B_LAST  = BW'(VERTEX_COUNT + EDGE_COUNT - 1);
  localparam logic [BW-1:0]   V_CNT   = BW'(VERTEX_COUNT);

  typedef enum logic [1:0] {IDLE, FETCH_V, FETCH_E, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     issue_cnt;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     edge_off;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic              credit_ok, issue, last_issue;
  logic              push, pop, stale, start_acc, last_beat;
  logic              done_q, err_q;

  // Reads in flight plus records parked in the FIFO never exceed its depth,
  // so every return is guaranteed a slot.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < DEPTH_C;
  assign start_acc   = (state == IDLE) && start;
  assign push        = bus.mem_rd_valid && (outstanding != '0);
  assign stale       = bus.mem_rd_valid && (outstanding == '0);
  assign pop         = bus.out_valid && bus.out_ready;
  assign last_beat   = pop && (beat_cnt == B_LAST) && (outstanding == '0);

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, read issue and address; the address holds between issues.
  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    last_issue   = 1'b0;
    bus.mem_addr = addr_q;
    case (state)
      IDLE: if (start) state_nxt = FETCH_V;
      FETCH_V: if (credit_ok) begin
        issue        = 1'b1;
        bus.mem_addr = VERTEX_BASE + ADDR_W'(issue_cnt);
        last_issue   = (issue_cnt == V_LAST);
        if (last_issue) state_nxt = FETCH_E;
      end
      FETCH_E: if (credit_ok) begin
        issue        = 1'b1;
        bus.mem_addr = EDGE_BASE + ADDR_W'(issue_cnt);
        last_issue   = (issue_cnt == E_LAST);
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_rd_en = issue;

  // Per-table issue counter and the held copy of the last issued address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt <= '0;
      addr_q    <= '0;
    end else begin
      if (start_acc)  issue_cnt <= '0;
      else if (issue) issue_cnt <= last_issue ? '0 : issue_cnt + 1'b1;
      if (issue) addr_q <= bus.mem_addr;
    end
  end

  // Reads issued but not yet returned; issue and return together cancel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (start_acc) begin
      outstanding <= '0;
    end else begin
      case ({issue, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Skid FIFO pointers and occupancy; push and pop may coincide at any fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rd_data;
  end

  // Accepted-beat counter that drives the region/index tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       beat_cnt <= '0;
    else if (start_acc) beat_cnt <= '0;
    else if (pop)       beat_cnt <= beat_cnt + 1'b1;
  end

  // Completion pulse and sticky protocol error for unsolicited returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && last_beat;
      if (stale)          err_q <= 1'b1;
      else if (start_acc) err_q <= 1'b0;
    end
  end

  assign edge_off        = beat_cnt - V_CNT;
  assign bus.out_valid   = (fifo_count != '0);
  assign bus.out_data    = fifo_mem[rd_ptr];
  assign bus.out_is_edge = (beat_cnt >= V_CNT);
  assign bus.out_index   = bus.out_is_edge ? 8'(edge_off) : 8'(beat_cnt);
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign proto_err       = err_q;

endmodule

// File: tb/tb_graph_mem_loader.sv
// tb/tb_graph_mem_loader.sv - self-checking bench for graph_mem_loader
module tb_graph_mem_loader;
  localparam int NV    = 256;
  localparam int NE    = 256;
  localparam int NT    = NV + NE;
  localparam int DEPTH = 4;

  typedef struct {
    int lat_lo;
    int lat_hi;
    int ready_pct;
    int hold;
    int restart_at;
    int b2b;
  } scen_t;

  typedef struct {
    int beat;
    int idx;
    int is_edge;
    int addr;
  } spot_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic busy, done, proto_err;

  graph_mem_loader_if #(.DATA_W(8), .ADDR_W(9)) bus ();

  graph_mem_loader #(
    .DATA_W(8), .ADDR_W(9), .VERTEX_COUNT(NV), .EDGE_COUNT(NE),
    .VERTEX_BASE(9'h000), .EDGE_BASE(9'h100), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .done(done), .proto_err(proto_err), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  int got [0:NT-1];
  int checks = 0, failures = 0;
  int cyc = 0;
  int lat_lo = 1, lat_hi = 1, ready_pct = 100, hold_until = 0;
  int restart_at = -1;
  bit restart_fired = 1'b0;
  bit start_req = 1'b0;
  int issued = 0, accepted = 0, done_cnt = 0, busy_gap = 0;
  int first_acc = 0, last_acc = 0, last_due = 0;
  bit stalled = 1'b0;
  int hold_bits = 0;
  int due_q[$];
  int addr_q[$];
  scen_t scen [5];
  spot_t spots [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int k);
    return (k < NV) ? k : 'h100 + (k - NV);
  endfunction

  function automatic int exp_beat(input int k);
    logic [7:0] idx;
    logic [7:0] d;
    if (k >= NT) return -1;
    idx = 8'((k < NV) ? k : k - NV);
    d   = mem[exp_addr(k)];
    return int'({d, idx, 1'(k >= NV)});
  endfunction

  // One clock of environment: memory model, consumer and monitors.
  task automatic step();
    int lat, due, act;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    if (start_req) begin
      start     = 1'b1;
      start_req = 1'b0;
    end
    if (restart_at >= 0 && !restart_fired && accepted == restart_at) begin
      start         = 1'b1;
      restart_fired = 1'b1;
    end
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = mem[addr_q[0]];
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end
    if (bus.mem_rd_en === 1'b1) begin
      chk("rd_addr", int'(bus.mem_addr), exp_addr(issued));
      chk("credit", (issued - accepted < DEPTH) ? 1 : 0, 1);
      lat = int'($urandom_range(lat_hi, lat_lo));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      due_q.push_back(due);
      addr_q.push_back(int'(bus.mem_addr));
      issued++;
    end
    if (cyc <= hold_until) bus.out_ready = 1'b0;
    else bus.out_ready = (int'($urandom_range(99, 0)) < ready_pct);
    act = int'({bus.out_data, bus.out_index, bus.out_is_edge});
    if (stalled) chk("stall_hold", int'({bus.out_valid, act[16:0]}), int'({1'b1, hold_bits[16:0]}));
    if (bus.out_valid === 1'b1) begin
      if (bus.out_ready) begin
        chk("beat", act, exp_beat(accepted));
        if (accepted < NT) got[accepted] = act;
        if (accepted == 0) first_acc = cyc;
        last_acc = cyc;
        accepted++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        hold_bits = act;
      end
    end else begin
      stalled = 1'b0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_delay", cyc - last_acc, 1);
      chk("busy_at_done", int'(busy), 0);
    end
  endtask

  task automatic begin_load(input scen_t s);
    lat_lo        = s.lat_lo;
    lat_hi        = s.lat_hi;
    ready_pct     = s.ready_pct;
    restart_at    = s.restart_at;
    restart_fired = 1'b0;
    issued        = 0;
    accepted      = 0;
    done_cnt      = 0;
    busy_gap      = 0;
    stalled       = 1'b0;
    last_due      = cyc;
    hold_until    = cyc + 1 + s.hold;
    start_req     = 1'b1;
    step();
  endtask

  task automatic run_load(input scen_t s);
    int budget;
    begin_load(s);
    budget = 5000;
    while (done_cnt == 0 && budget > 0) begin
      step();
      budget--;
      if (s.hold > 0 && cyc == hold_until) chk("bp_reads", issued, DEPTH);
      if (done_cnt == 0 && busy !== 1'b1) busy_gap++;
    end
    chk("load_done", done_cnt, 1);
    chk("beats", accepted, NT);
    chk("reads", issued, NT);
    chk("busy_gap", busy_gap, 0);
    if (s.b2b != 0) chk("b2b_span", last_acc - first_acc, NT - 1);
    repeat (4) step();
    chk("one_done", done_cnt, 1);
    chk("err_clear", int'(proto_err), 0);
    for (int i = 0; i < 4; i++)
      chk("spot", got[spots[i].beat],
          int'({mem[spots[i].addr], 8'(spots[i].idx), 1'(spots[i].is_edge)}));
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + i / 16 + 5);
    scen[0] = '{1, 1, 100, 0, -1, 1};
    scen[1] = '{2, 2, 100, 20, -1, 0};
    scen[2] = '{1, 1, 100, 0, 100, 1};
    scen[3] = '{1, 3, 50, 0, -1, 0};
    scen[4] = '{3, 3, 80, 0, -1, 0};
    spots[0] = '{0, 'h00, 0, 'h000};
    spots[1] = '{255, 'hFF, 0, 'h0FF};
    spots[2] = '{256, 'h00, 1, 'h100};
    spots[3] = '{511, 'hFF, 1, 'h1FF};

    reset_n          = 1'b0;
    start            = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    bus.out_ready    = 1'b0;
    step();
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(bus.mem_rd_en), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_err", int'(proto_err), 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_load(scen[i]);

    // Reset in the middle of a load, then two stale memory returns.
    begin_load('{2, 2, 100, 0, -1, 0});
    budget = 3000;
    while (accepted < 300 && budget > 0) begin
      step();
      budget--;
    end
    chk("reach_300", accepted, 300);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rd_en", int'(bus.mem_rd_en), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_addr", int'(bus.mem_addr), 0);
    chk("mid_rst_done", int'(done), 0);
    while (due_q.size() > 2) begin
      void'(due_q.pop_back());
      void'(addr_q.pop_back());
    end
    chk("stale_setup", due_q.size(), 2);
    if (due_q.size() == 2) begin
      due_q[0] = cyc + 2;
      due_q[1] = cyc + 3;
    end
    stalled = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (4) step();
    chk("stale_err", int'(proto_err), 1);
    chk("stale_dropped", int'(bus.out_valid), 0);
    chk("stale_idle", int'(busy), 0);
    run_load(scen[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
